// File: rtl/movegen_sequencer_if.sv
// ----------------------------------------------------------------------------
// movegen_sequencer_if
// Purpose : (from,to) move stream from the move-generation sequencer to the
//           search / move-list stage over a valid/ready handshake.
// Signals : move_valid  move available (producer)
//           move_from   source square index 0..63 (producer)
//           move_to     destination square index 0..63 (producer)
//           move_ready  consumer accepts the presented move (consumer)
// Modports: master = sequencer side, slave = consumer side.
// ----------------------------------------------------------------------------
interface movegen_sequencer_if;
    logic       move_valid;
    logic [5:0] move_from;
    logic [5:0] move_to;
    logic       move_ready;

    modport master (
        output move_valid,
        output move_from,
        output move_to,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_from,
        input  move_to,
        output move_ready
    );
endinterface

// File: rtl/movegen_sequencer.sv
// ----------------------------------------------------------------------------
// movegen_sequencer
// Purpose : Downstream controller for the 8x8 movegen_square array. Walks the
//           side-to-move's pieces one source square at a time (ascending idx),
//           pulses that square's emit_move, waits SETTLE_CYCLES for the board's
//           combinational move paths, latches the 64-bit target vector and
//           streams every target as one (from,to) move (ascending to).
//           Square idx = (RANK-1)*8 + (FILE-1); a1=0, h1=7, a8=56, h8=63.
// Params  : SETTLE_CYCLES  cycles emit_move is held before sampling i_target
//                          (legal range 1..15)
// Ports   : clk, rst        clock, synchronous active-high reset
//           i_start         begin a pass (honoured only when idle)
//           i_from_mask     squares holding side-to-move pieces
//           i_target        target_square outputs of all 64 squares
//           o_emit_move     one-hot emit_move, zero outside settling
//           mv (master)     move_valid / move_from / move_to / move_ready
//           o_busy          pass in progress
//           o_done          one-cycle pulse at end of pass
//           o_move_count    moves accepted in this pass
// Config  : `define MOVEGEN_SEQ_COUNT_EN to build the saturating accepted-move
//           counter; otherwise o_move_count is tied to zero.
// All outputs are registered.
// ----------------------------------------------------------------------------
module movegen_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [63:0]               i_from_mask,
    input  logic [63:0]               i_target,
    output logic [63:0]               o_emit_move,
    movegen_sequencer_if.master       mv,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [7:0]                o_move_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Counter runs SETTLE_LOAD..0, so SETTLE spans exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [2:0]  state_q,    state_d;
    logic [63:0] rem_from_q, rem_from_d;
    logic [63:0] rem_to_q,   rem_to_d;
    logic [5:0]  from_q,     from_d;
    logic [5:0]  to_q,       to_d;
    logic [63:0] emit_q,     emit_d;
    logic        valid_q,    valid_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [3:0]  settle_q,   settle_d;

    function automatic logic [5:0] lowest_idx(input logic [63:0] v);
        logic [5:0] r;
        r = '0;
        // Scan high to low so the last hit is the lowest set bit.
        for (int unsigned i = 0; i < 64; i++) begin
            if (v[63 - i]) r = 6'(63 - i);
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        rem_from_d = rem_from_q;
        rem_to_d   = rem_to_q;
        from_d     = from_q;
        to_d       = to_q;
        emit_d     = emit_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        settle_d   = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    rem_from_d = i_from_mask;
                    busy_d     = 1'b1;
                    state_d    = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rem_from_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    from_d             = lowest_idx(rem_from_q);
                    rem_from_d[from_d] = 1'b0;
                    emit_d             = '0;
                    emit_d[from_d]     = 1'b1;
                    settle_d           = SETTLE_LOAD;
                    state_d            = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    // First move is registered on the sampling edge so valid
                    // is already up in the first EMIT cycle.
                    emit_d   = '0;
                    rem_to_d = i_target;
                    valid_d  = |i_target;
                    to_d     = lowest_idx(i_target);
                    state_d  = ST_EMIT;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_EMIT: begin
                if (!valid_q) begin
                    state_d = ST_SELECT;
                end else if (mv.move_ready) begin
                    rem_to_d[to_q] = 1'b0;
                    if (rem_to_d == '0) begin
                        valid_d = 1'b0;
                        state_d = ST_SELECT;
                    end else begin
                        to_d = lowest_idx(rem_to_d);
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_from_q <= '0;
            rem_to_q   <= '0;
            from_q     <= '0;
            to_q       <= '0;
            emit_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            rem_from_q <= rem_from_d;
            rem_to_q   <= rem_to_d;
            from_q     <= from_d;
            to_q       <= to_d;
            emit_q     <= emit_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            settle_q   <= settle_d;
        end
    end

`ifdef MOVEGEN_SEQ_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == ST_IDLE && i_start) begin
            count_d = '0;
        end else if (valid_q && mv.move_ready && count_q != '1) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign o_move_count = count_q;
`else
    assign o_move_count = '0;
`endif

    assign o_emit_move   = emit_q;
    assign mv.move_valid = valid_q;
    assign mv.move_from  = from_q;
    assign mv.move_to    = to_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule
